// File: rtl/host_stream_router.sv
// Packs a packetised host beat stream LSB-first into wide words and writes them to one of NUM_CH ports.
// Optional build macro HSR_CHECKSUM_EN adds a trailing XOR checksum beat per packet.
module host_stream_router #(
  parameter int unsigned IN_WIDTH   = 16,
  parameter int unsigned OUT_WIDTH  = 512,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [NUM_CH-1:0]     ch_rdy,
  output logic [NUM_CH-1:0]     ch_wen,
  output logic [ADDR_WIDTH-1:0] wadr,
  output logic [OUT_WIDTH-1:0]  wdata,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned RATIO     = OUT_WIDTH / IN_WIDTH;
  localparam int unsigned CH_BITS   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_BITS  = IN_WIDTH - CH_BITS;
  localparam int unsigned BEAT_BITS = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_CSUM
  } state_t;

  state_t                state;
  logic [CH_BITS-1:0]    ch;
  logic [CNT_BITS-1:0]   words_left;
  logic [BEAT_BITS-1:0]  beat_cnt;
  logic [OUT_WIDTH-1:0]  acc;
  logic                  word_pend;
`ifdef HSR_CHECKSUM_EN
  logic [IN_WIDTH-1:0]   csum;
`endif

  logic                  sel_rdy;
  logic                  ch_ok;
  logic                  hdr_ok;
  logic                  write;
  logic                  accept;
  logic                  last_beat;
  logic [OUT_WIDTH-1:0]  word_next;

  assign ch_ok     = (32'(ch) < NUM_CH);
  assign hdr_ok    = (32'(in_data[IN_WIDTH-1 -: CH_BITS]) < NUM_CH);
  assign last_beat = (beat_cnt == BEAT_BITS'(RATIO - 1));

  // Channel-select of the ready/strobe; word_pend is only ever set for a valid channel.
  always_comb begin
    sel_rdy = 1'b0;
    ch_wen  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch == CH_BITS'(i)) begin
        sel_rdy   = ch_rdy[i];
        ch_wen[i] = word_pend && ch_rdy[i];
      end
    end
  end

  assign write  = |ch_wen;
  assign in_rdy = !(word_pend && !sel_rdy);
  assign accept = in_vld && in_rdy;
  assign busy   = (state != S_IDLE) || word_pend;

  // Accumulator with the current beat dropped into its slot.
  always_comb begin
    word_next = acc;
    word_next[32'(beat_cnt) * IN_WIDTH +: IN_WIDTH] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ch         <= '0;
      words_left <= '0;
      beat_cnt   <= '0;
      acc        <= '0;
      word_pend  <= 1'b0;
      err        <= 1'b0;
      wadr       <= '0;
      wdata      <= '0;
`ifdef HSR_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      if (write) begin
        word_pend <= 1'b0;
        wadr      <= wadr + 1'b1;
      end
      if (accept) begin
        case (state)
          S_IDLE: begin
            ch         <= in_data[IN_WIDTH-1 -: CH_BITS];
            words_left <= in_data[CNT_BITS-1:0];
            beat_cnt   <= '0;
            if (!hdr_ok) err <= 1'b1;
            state      <= S_ADDR;
          end
          S_ADDR: begin
            wadr  <= in_data[ADDR_WIDTH-1:0];
`ifdef HSR_CHECKSUM_EN
            csum  <= in_data;
`endif
            state <= S_DATA;
          end
          S_DATA: begin
`ifdef HSR_CHECKSUM_EN
            csum <= csum ^ in_data;
`endif
            if (last_beat) begin
              beat_cnt <= '0;
              acc      <= '0;
              wdata    <= word_next;
              if (ch_ok) word_pend <= 1'b1;
              if (words_left == '0) begin
`ifdef HSR_CHECKSUM_EN
                state <= S_CSUM;
`else
                state <= S_IDLE;
`endif
              end else begin
                words_left <= words_left - 1'b1;
              end
            end else begin
              acc      <= word_next;
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
          S_CSUM: begin
`ifdef HSR_CHECKSUM_EN
            if (in_data != csum) err <= 1'b1;
`endif
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_host_stream_router.sv
// Directed + randomized bench for host_stream_router (3 channels so an invalid channel code exists).
`timescale 1ns/1ps
module tb_host_stream_router;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 512;
  localparam int unsigned NCH   = 3;
  localparam int unsigned AW    = 9;
  localparam int unsigned RATIO = OUT_W / IN_W;
  localparam int unsigned CHB   = 2;
  localparam int unsigned CNTB  = IN_W - CHB;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_vld = 1'b0;
  logic             in_rdy;
  logic [NCH-1:0]   ch_rdy = '1;
  logic [NCH-1:0]   ch_wen;
  logic [AW-1:0]    wadr;
  logic [OUT_W-1:0] wdata;
  logic             busy;
  logic             err;

  host_stream_router #(
    .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .NUM_CH(NCH), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .ch_rdy(ch_rdy), .ch_wen(ch_wen), .wadr(wadr), .wdata(wdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0]   wen;
    logic [AW-1:0]    adr;
    logic [OUT_W-1:0] data;
    int               cyc;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  bubbles = 0;
  int  last_cyc = 0;
  bit  err_exp = 1'b0;
  bit  rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n && ch_wen != '0) obs_q.push_back('{ch_wen, wadr, wdata, cyc});

  always @(posedge clk)
    if (rand_rdy) begin
      #1;
      if (rand_rdy) ch_rdy = NCH'($urandom);
    end

  task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    in_vld = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic drive(input logic [IN_W-1:0] d);
    bit ok;
    ok = 1'b0;
    in_vld  = 1'b1;
    in_data = d;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_rdy;
      if (ok) last_cyc = cyc;
      else bubbles++;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("beat_accept_timeout", ok, 1'b1);
  endtask

  // Send one packet and push the words the spec says must be written.
  task automatic send_packet(input int ch, input int n, input logic [IN_W-1:0] adr_beat,
                             input bit ramp, input int stall_word, input bit gaps,
                             input bit timing, input bit bad_csum);
    logic [IN_W-1:0]  b;
    logic [IN_W-1:0]  x;
    logic [OUT_W-1:0] w;
    logic [AW-1:0]    a;
    wr_t              e;
    a = adr_beat[AW-1:0];
    if (ch >= int'(NCH)) err_exp = 1'b1;
    drive({CHB'(ch), CNTB'(n)});
    drive(adr_beat);
    x = adr_beat;
    for (int k = 0; k <= n; k++) begin
      w = '0;
      for (int j = 0; j < int'(RATIO); j++) begin
        b = ramp ? IN_W'(k * int'(RATIO) + j) : IN_W'($urandom);
        if (gaps && $urandom_range(0, 3) == 0) idle(1);
        drive(b);
        x = x ^ b;
        w[j*IN_W +: IN_W] = b;
      end
      if (ch < int'(NCH)) begin
        e.wen  = NCH'(1) << ch;
        e.adr  = a;
        e.data = w;
        e.cyc  = timing ? last_cyc + 1 : 0;
        exp_q.push_back(e);
      end
      a = a + 1'b1;
      if (k == stall_word && ch < int'(NCH)) begin
        ch_rdy[ch] = 1'b0;
        in_vld  = 1'b1;
        in_data = '1;
        for (int t = 0; t < 10; t++) begin
          @(negedge clk);
          chk("stall_in_rdy", in_rdy, 1'b0);
          chk("stall_ch_wen", ch_wen, '0);
          @(posedge clk);
          #1;
        end
        ch_rdy = '1;
      end
    end
`ifdef HSR_CHECKSUM_EN
    drive(bad_csum ? ~x : x);
    if (bad_csum) err_exp = 1'b1;
`else
    if (bad_csum) x = '0;
`endif
  endtask

  task automatic flush(input string tag);
    wr_t o;
    wr_t e;
    idle(4);
    chk({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_wen"}, o.wen, e.wen);
      chk({tag, "_wadr"}, o.adr, e.adr);
      chk({tag, "_wdata"}, o.data, e.data);
      if (e.cyc != 0) chk({tag, "_wcycle"}, o.cyc, e.cyc);
    end
    exp_q.delete();
    obs_q.delete();
    chk({tag, "_err"}, err, err_exp);
    chk({tag, "_busy_idle"}, busy, 1'b0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_rdy"}, in_rdy, 1'b1);
    chk({tag, "_ch_wen"}, ch_wen, '0);
    chk({tag, "_wadr"}, wadr, '0);
    chk({tag, "_wdata"}, wdata, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    #12;
    reset_checks("rst");
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single word to ch0, ramp payload
    send_packet(0, 0, 16'h0005, 1'b1, -1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_busy_after_last", busy, 1'b1);
    flush("t1");

    // two words to ch1 across the address wrap with a 10-cycle stall
    send_packet(1, 1, 16'h01FF, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    flush("t2");

    // back-to-back packets, no bubbles, write the cycle after the last beat
    bubbles = 0;
    send_packet(0, 0, 16'($urandom), 1'b0, -1, 1'b0, 1'b1, 1'b0);
    send_packet(1, 1, 16'($urandom), 1'b0, -1, 1'b0, 1'b1, 1'b0);
    chk("t3_bubbles", bubbles, 0);
    flush("t3");

    // invalid channel consumed at full rate, err sticky
    bubbles = 0;
    send_packet(3, 0, 16'h0010, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    chk("t4_bubbles", bubbles, 0);
    flush("t4");
    send_packet(2, 0, 16'h0020, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    flush("t4_sticky");

    // reset mid-word
    drive({CHB'(0), CNTB'(0)});
    drive(16'h0030);
    for (int j = 0; j < 10; j++) drive(IN_W'($urandom));
    #2 rst_n = 1'b0;
    #1 reset_checks("t5_async");
    in_vld = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    err_exp = 1'b0;
    exp_q.delete();
    obs_q.delete();
    send_packet(2, 0, 16'h0044, 1'b0, -1, 1'b0, 1'b1, 1'b0);
    flush("t5_next");

    // randomized packets, gaps and destination backpressure
    rand_rdy = 1'b1;
    for (int p = 0; p < 6; p++)
      send_packet(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 16'($urandom),
                  1'b0, -1, 1'b1, 1'b0, 1'b0);
    rand_rdy = 1'b0;
    idle(1);
    ch_rdy = '1;
    flush("rand");

`ifdef HSR_CHECKSUM_EN
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    err_exp = 1'b0;
    @(posedge clk);
    #1;
    send_packet(0, 0, 16'h0055, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    flush("t6_good");
    send_packet(1, 0, 16'h0066, 1'b0, -1, 1'b0, 1'b0, 1'b1);
    flush("t6_bad");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
